// File: rtl/mac_result_wb.sv
// rtl/mac_result_wb.sv - MAC result write-back stage: 2-entry skid buffer with IEEE packing and flag accumulation
//
// Packs rounder results into {sign, exp, mant}, substitutes canonical NaN on
// invalid operations, and holds them in a main+skid buffer toward the
// register file write port. Optional sticky flag accumulator is built only
// when MAC_FFLAGS_ACC_EN is defined; otherwise Fflags_acc_o is tied to 0.
//
// Ports:
//   clk_i, rst_i             clock (rising edge), async active-high reset
//   Valid_i / Ready_o        upstream handshake (Ready_o is a flop output)
//   Sign_i, Exp_i, Mant_i    rounder result fields
//   Invalid_i .. Inexact_i   rounder exception flags
//   Valid_o / Ready_i        downstream handshake
//   Result_o, Fflags_o       main entry result and {NV,DZ,OF,UF,NX}; 0 when empty
//   Fflags_clr_i             clear accumulated flags
//   Fflags_acc_o             accumulated flags, same bit order

module mac_result_wb #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           Valid_i,
    output logic                           Ready_o,
    input  logic                           Sign_i,
    input  logic [PARM_EXP-1:0]            Exp_i,
    input  logic [PARM_MANT-1:0]           Mant_i,
    input  logic                           Invalid_i,
    input  logic                           Overflow_i,
    input  logic                           Underflow_i,
    input  logic                           Inexact_i,
    output logic                           Valid_o,
    input  logic                           Ready_i,
    output logic [PARM_EXP+PARM_MANT:0]    Result_o,
    output logic [4:0]                     Fflags_o,
    input  logic                           Fflags_clr_i,
    output logic [4:0]                     Fflags_acc_o
);

    localparam int W = PARM_EXP + PARM_MANT + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           ready_q;

    logic [W-1:0]   main_res;
    logic [4:0]     main_fl;
    logic [W-1:0]   skid_res;
    logic [4:0]     skid_fl;

    logic           accept;
    logic           retire;
    logic           load_main;
    logic           load_skid;
    logic           skid_to_main;

    logic [W-1:0]   in_res;
    logic [4:0]     in_fl;

    // Canonical quiet NaN: positive, exponent all ones, only the quiet bit set.
    localparam logic [W-1:0] CANON_NAN =
        {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

    always_comb begin
        in_res = Invalid_i ? CANON_NAN : {Sign_i, Exp_i, Mant_i};
        in_fl  = {Invalid_i, 1'b0, Overflow_i, Underflow_i, Inexact_i};
    end

    assign Ready_o = ready_q;
    assign Valid_o = (state != ST_EMPTY);
    assign accept  = Valid_i & ready_q;
    assign retire  = Valid_o & Ready_i;

    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && retire) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = ST_TWO;
                end else if (retire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Ready_o is low here, so nothing can be accepted alongside.
                if (retire) begin
                    skid_to_main = 1'b1;
                    state_nxt    = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            // Registered ready: computed from next state, never from Ready_i directly.
            ready_q <= (state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_res <= '0;
            main_fl  <= '0;
            skid_res <= '0;
            skid_fl  <= '0;
        end else begin
            if (load_main) begin
                main_res <= in_res;
                main_fl  <= in_fl;
            end else if (skid_to_main) begin
                main_res <= skid_res;
                main_fl  <= skid_fl;
            end
            if (load_skid) begin
                skid_res <= in_res;
                skid_fl  <= in_fl;
            end
        end
    end

    assign Result_o = Valid_o ? main_res : '0;
    assign Fflags_o = Valid_o ? main_fl  : 5'b0;

`ifdef MAC_FFLAGS_ACC_EN
    logic [4:0] acc_q;

    // A clear coinciding with a retire keeps only the retiring flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= 5'b0;
        end else if (Fflags_clr_i) begin
            acc_q <= retire ? Fflags_o : 5'b0;
        end else if (retire) begin
            acc_q <= acc_q | Fflags_o;
        end
    end

    assign Fflags_acc_o = acc_q;
`else
    logic unused_fflags_clr;

    assign unused_fflags_clr = Fflags_clr_i;
    assign Fflags_acc_o      = 5'b0;
`endif

endmodule

// File: tb/tb_mac_result_wb.sv
// tb/tb_mac_result_wb.sv - self-checking bench for mac_result_wb against a FIFO reference model
module tb_mac_result_wb;

    localparam int E = 8;
    localparam int M = 23;
    localparam int W = E + M + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_in;
    logic           ready_out;
    logic           sign_in;
    logic [E-1:0]   exp_in;
    logic [M-1:0]   mant_in;
    logic           inv_in, ovf_in, unf_in, nx_in;
    logic           valid_out;
    logic           ready_in;
    logic [W-1:0]   result_out;
    logic [4:0]     fflags_out;
    logic           clr_in;
    logic [4:0]     acc_out;

    mac_result_wb #(.PARM_EXP(E), .PARM_MANT(M)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .Valid_i      (valid_in),
        .Ready_o      (ready_out),
        .Sign_i       (sign_in),
        .Exp_i        (exp_in),
        .Mant_i       (mant_in),
        .Invalid_i    (inv_in),
        .Overflow_i   (ovf_in),
        .Underflow_i  (unf_in),
        .Inexact_i    (nx_in),
        .Valid_o      (valid_out),
        .Ready_i      (ready_in),
        .Result_o     (result_out),
        .Fflags_o     (fflags_out),
        .Fflags_clr_i (clr_in),
        .Fflags_acc_o (acc_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic [4:0]   f;
    } ent_t;

    ent_t        q[$];
    logic [4:0]  acc_m;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // Expected packed result from the arithmetic definition of canonical NaN.
    function automatic ent_t model_pack(input logic s, input logic [E-1:0] e, input logic [M-1:0] m,
                                        input logic nv, input logic of, input logic uf, input logic nx);
        ent_t x;
        if (nv) x.r = W'(((2 ** E) - 1) * (2 ** M) + (2 ** (M - 1)));
        else    x.r = {s, e, m};
        x.f = {nv, 1'b0, of, uf, nx};
        return x;
    endfunction

    task automatic check_outputs();
        chk("valid_o", 32'(valid_out), 32'(q.size() > 0));
        chk("ready_o", 32'(ready_out), 32'(q.size() < 2));
        chk("result_o", 32'(result_out), (q.size() > 0) ? 32'(q[0].r) : 32'h0);
        chk("fflags_o", 32'(fflags_out), (q.size() > 0) ? 32'(q[0].f) : 32'h0);
        chk("fflags_acc_o", 32'(acc_out), 32'(acc_m));
    endtask

    // One clock: entered and left at a negedge. Outputs are checked first,
    // then inputs are driven and the model steps across the posedge.
    task automatic cycle(input logic v, input logic s, input logic [E-1:0] e, input logic [M-1:0] m,
                         input logic nv, input logic of, input logic uf, input logic nx,
                         input logic rdy, input logic clr, output logic took);
        logic acc_now, ret_now;
        ent_t x;
        check_outputs();
        valid_in = v; sign_in = s; exp_in = e; mant_in = m;
        inv_in = nv; ovf_in = of; unf_in = uf; nx_in = nx;
        ready_in = rdy; clr_in = clr;
        #1;
        acc_now = v && (q.size() < 2);
        ret_now = rdy && (q.size() > 0);
        x = model_pack(s, e, m, nv, of, uf, nx);
        @(posedge clk);
`ifdef MAC_FFLAGS_ACC_EN
        if (clr)          acc_m = ret_now ? q[0].f : 5'b0;
        else if (ret_now) acc_m = acc_m | q[0].f;
`endif
        if (ret_now) void'(q.pop_front());
        if (acc_now) q.push_back(x);
        took = acc_now;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        logic t;
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0, t);
    endtask

    logic took;

    initial begin
        rst = 1'b1;
        valid_in = 0; sign_in = 0; exp_in = '0; mant_in = '0;
        inv_in = 0; ovf_in = 0; unf_in = 0; nx_in = 0;
        ready_in = 0; clr_in = 0;
        acc_m = 5'b0;
        #2;
        chk("reset valid_o", 32'(valid_out), 32'h0);
        chk("reset ready_o", 32'(ready_out), 32'h1);
        chk("reset result_o", 32'(result_out), 32'h0);
        chk("reset acc", 32'(acc_out), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Simple normal result, inexact only.
        cycle(1'b1, 1'b0, 8'h80, 23'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, took);
        chk("lit result 2.0", 32'(result_out), 32'h40000000);
        chk("lit flags NX", 32'(fflags_out), 32'h01);
        chk("lit valid", 32'(valid_out), 32'h1);
        idle(1'b1);
        chk("lit valid drops", 32'(valid_out), 32'h0);

        // Invalid forces canonical NaN regardless of sign/mantissa.
        cycle(1'b1, 1'b1, 8'h12, 23'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, took);
        chk("lit nan", 32'(result_out), 32'h7FC00000);
        chk("lit flags NV", 32'(fflags_out), 32'h10);
        idle(1'b1);

        // Backpressure: A,B fill the buffer, C waits upstream.
        cycle(1'b1, 1'b0, 8'h01, 23'h00000A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, took);
        cycle(1'b1, 1'b0, 8'h02, 23'h00000B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, took);
        chk("ready low after B", 32'(ready_out), 32'h0);
        cycle(1'b1, 1'b0, 8'h03, 23'h00000C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, took);
        chk("C not taken", 32'(took), 32'h0);
        chk("A held", 32'(result_out), 32'h0080000A);
        took = 1'b0;
        for (int i = 0; i < 6 && !took; i++)
            cycle(1'b1, 1'b0, 8'h03, 23'h00000C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, took);
        chk("C eventually taken", 32'(took), 32'h1);
        for (int i = 0; i < 4; i++) idle(1'b1);

`ifdef MAC_FFLAGS_ACC_EN
        cycle(1'b1, 1'b0, 8'h10, 23'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, took);
        cycle(1'b1, 1'b0, 8'h11, 23'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, took);
        idle(1'b1);
        chk("lit acc 00111", 32'(acc_out), 32'h07);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, took);
        chk("lit acc cleared", 32'(acc_out), 32'h00);
        cycle(1'b1, 1'b0, 8'h10, 23'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, took);
        idle(1'b1);
        cycle(1'b1, 1'b0, 8'h10, 23'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, took);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, took);
        chk("lit acc clr+NV", 32'(acc_out), 32'h10);
`endif

        // Async reset while TWO entries are buffered.
        cycle(1'b1, 1'b0, 8'h21, 23'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, took);
        cycle(1'b1, 1'b0, 8'h22, 23'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, took);
        chk("two entries", 32'(ready_out), 32'h0);
        valid_in = 1'b0;
        ready_in = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async rst valid_o", 32'(valid_out), 32'h0);
        chk("async rst ready_o", 32'(ready_out), 32'h1);
        chk("async rst result_o", 32'(result_out), 32'h0);
        chk("async rst fflags_o", 32'(fflags_out), 32'h0);
        q.delete();
        acc_m = 5'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Randomized traffic with upstream holding a pending item until taken.
        begin
            logic           pv, ps, pnv, pof, puf, pnx;
            logic [E-1:0]   pe;
            logic [M-1:0]   pm;
            pv = 0; ps = 0; pnv = 0; pof = 0; puf = 0; pnx = 0; pe = '0; pm = '0;
            for (int n = 0; n < 600; n++) begin
                if (!pv) begin
                    pv  = ($urandom_range(0, 9) < 7);
                    ps  = 1'($urandom);
                    pe  = E'($urandom);
                    pm  = M'($urandom);
                    pnv = ($urandom_range(0, 4) == 0);
                    pof = 1'($urandom);
                    puf = 1'($urandom);
                    pnx = 1'($urandom);
                end
                cycle(pv, ps, pe, pm, pnv, pof, puf, pnx,
                      ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0), took);
                if (took) pv = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_result_wb.md
MAC_RESULT_WB -- requirements
Module: mac_result_wb

Interface
REQ-001 SHALL have parameter PARM_EXP, default 8, exponent width.
REQ-002 SHALL have parameter PARM_MANT, default 23, stored mantissa width; result width W = PARM_EXP+PARM_MANT+1.
REQ-003 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port Valid_i, input, 1, upstream rounder result valid.
REQ-006 SHALL have port Ready_o, output, 1, block can accept this cycle.
REQ-007 SHALL have port Sign_i, input, 1, result sign from rounder.
REQ-008 SHALL have port Exp_i, input, PARM_EXP, result exponent from rounder.
REQ-009 SHALL have port Mant_i, input, PARM_MANT, result mantissa from rounder.
REQ-010 SHALL have ports Invalid_i, Overflow_i, Underflow_i, Inexact_i, input, 1 each, rounder exception flags.
REQ-011 SHALL have port Valid_o, output, 1, packed result valid.
REQ-012 SHALL have port Ready_i, input, 1, downstream (register file write port) ready.
REQ-013 SHALL have port Result_o, output, W, packed {sign, exp, mant}.
REQ-014 SHALL have port Fflags_o, output, 5, per-result flags {NV,DZ,OF,UF,NX}, bit4 = NV.
REQ-015 SHALL have port Fflags_clr_i, input, 1, clear accumulated flags.
REQ-016 SHALL have port Fflags_acc_o, output, 5, accumulated flags, same bit order.

Function
REQ-017 SHALL accept an entry when Valid_i & Ready_o on a rising edge; SHALL retire when Valid_o & Ready_i.
REQ-018 SHALL implement a 2-entry skid buffer (main + skid) with states EMPTY, ONE, TWO.
REQ-019 Transitions: EMPTY-accept->ONE; ONE-accept&!retire->TWO; ONE-retire&!accept->EMPTY; ONE-accept&retire->ONE; TWO-retire->ONE (skid moves to main); otherwise hold.
REQ-020 Ready_o SHALL be registered: 1 in EMPTY/ONE, 0 in TWO; no combinational path from Ready_i to Ready_o.
REQ-021 Valid_o SHALL be 1 in ONE/TWO, 0 in EMPTY; Result_o/Fflags_o SHALL show main entry and hold stable while Valid_o & !Ready_i.
REQ-022 Latency: accept at edge N SHALL give Valid_o high after edge N when buffer was EMPTY; throughput 1 result/cycle when Ready_i held high.
REQ-023 When Invalid_i=1 the stored result SHALL be canonical NaN: sign 0, exp all ones, mant MSB 1, rest 0 (0x7FC00000 default), regardless of Sign_i/Mant_i.
REQ-024 Otherwise stored result SHALL be {Sign_i, Exp_i, Mant_i} unchanged.
REQ-025 Stored flags SHALL be {Invalid_i, 1'b0, Overflow_i, Underflow_i, Inexact_i}; DZ always 0.
REQ-026 Ordering SHALL be strict FIFO; no entry dropped or duplicated, including TWO-state retire with Valid_i high (Ready_o=0, so not accepted).
REQ-027 Result_o/Fflags_o SHALL read 0 when in EMPTY.

Reset
REQ-028 rst_i=1 SHALL immediately force state EMPTY, Valid_o=0, Ready_o=1, Result_o=0, Fflags_o=0, Fflags_acc_o=0, discarding buffered entries mid-operation.
REQ-029 First accept SHALL be possible on the first rising edge after rst_i deasserts.

Configuration
REQ-030 With macro MAC_FFLAGS_ACC_EN defined: on retire Fflags_acc_o <= Fflags_acc_o | Fflags_o; on Fflags_clr_i Fflags_acc_o <= 0; clear and retire in the same cycle SHALL give Fflags_acc_o = retiring Fflags_o only.
REQ-031 Without MAC_FFLAGS_ACC_EN: no accumulator register; Fflags_acc_o SHALL be tied 0 and Fflags_clr_i ignored.

Verification
REQ-032 Reset, Ready_i=1, send {0,0x80,0x000000}, Inexact_i=1 -> next cycle Result_o=0x40000000, Fflags_o=5'b00001, Valid_o=1 for one cycle.
REQ-033 Invalid_i=1, Sign_i=1, Mant_i=0x7FFFFF -> Result_o=0x7FC00000, Fflags_o=5'b10000.
REQ-034 Ready_i=0, push A,B,C back-to-back -> Ready_o=0 after B, C held upstream; raise Ready_i -> A,B,C retire in order, no loss.
REQ-035 MAC_FFLAGS_ACC_EN: retire OF|NX (5'b00101) then UF (5'b00010) -> Fflags_acc_o=5'b00111; pulse Fflags_clr_i alone -> 5'b00000; clear with NV retire -> 5'b10000.
REQ-036 Assert rst_i asynchronously in TWO -> Valid_o=0, Ready_o=1 before next edge; buffered entries never appear.
